// File: rtl/kf8259_interrupt_sequencer_if.sv
// Interrupt sequencer bus: IRR/IMR/INTA/EOI inputs and the ISR, INT and vector outputs.
// KF8259_AUTO_ROTATE_EN adds the rotate_on_eoi input.
interface kf8259_interrupt_sequencer_if;
    logic [7:0] i_interrupt_request_register;
    logic [7:0] i_interrupt_mask;
    logic       i_interrupt_acknowledge;
    logic       i_non_specific_eoi;
    logic       i_specific_eoi;
    logic [2:0] i_eoi_level;
    logic       i_auto_eoi_config;
    logic [4:0] i_vector_base;
`ifdef KF8259_AUTO_ROTATE_EN
    logic       i_rotate_on_eoi;
`endif
    logic       o_freeze;
    logic [7:0] o_clear_interrupt_request;
    logic [7:0] o_in_service_register;
    logic       o_interrupt_out;
    logic [7:0] o_vector;
    logic       o_vector_valid;

    modport slave (
`ifdef KF8259_AUTO_ROTATE_EN
        input  i_rotate_on_eoi,
`endif
        input  i_interrupt_request_register, i_interrupt_mask, i_interrupt_acknowledge,
        input  i_non_specific_eoi, i_specific_eoi, i_eoi_level, i_auto_eoi_config, i_vector_base,
        output o_freeze, o_clear_interrupt_request, o_in_service_register,
        output o_interrupt_out, o_vector, o_vector_valid
    );

    modport master (
`ifdef KF8259_AUTO_ROTATE_EN
        output i_rotate_on_eoi,
`endif
        output i_interrupt_request_register, i_interrupt_mask, i_interrupt_acknowledge,
        output i_non_specific_eoi, i_specific_eoi, i_eoi_level, i_auto_eoi_config, i_vector_base,
        input  o_freeze, o_clear_interrupt_request, o_in_service_register,
        input  o_interrupt_out, o_vector, o_vector_valid
    );
endinterface

// File: rtl/kf8259_interrupt_sequencer.sv
// KF8259 priority resolver and 8086 two-pulse INTA sequencer with ISR and EOI handling.
// KF8259_AUTO_ROTATE_EN enables rotating priority; otherwise IR0 is fixed highest.
module kf8259_interrupt_sequencer #(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    kf8259_interrupt_sequencer_if.slave   bus
);
    // state     | meaning
    // ST_IDLE   | resolving priority, waiting for first INTA
    // ST_ACK2   | level captured, IRR frozen, waiting for second INTA
    // ST_VECTOR | vector on the bus for one cycle
    typedef enum logic [1:0] {ST_IDLE, ST_ACK2, ST_VECTOR} state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_isr, w_isr_next;
    logic [7:0] r_clear, w_clear_next;
    logic [7:0] r_vector, w_vector_next;
    logic       r_vector_valid, w_vector_valid_next;
    logic       r_freeze, w_freeze_next;
    logic       r_int_out, w_int_out_next;
    logic [2:0] r_level, w_level_next;
    logic       r_spurious, w_spurious_next;

    logic [2:0]  w_lowest;
    logic [2:0]  w_shift;
    logic [7:0]  w_pending;
    logic [15:0] w_pend_dbl, w_isr_dbl;
    logic [7:0]  w_pend_rot, w_isr_rot;
    logic [2:0]  w_pend_idx, w_isr_idx;
    logic        w_pend_found, w_isr_found;
    logic        w_eligible;
    logic [2:0]  w_eligible_level, w_ns_level;
    logic [7:0]  w_set_mask, w_aeoi_mask, w_ns_mask, w_sp_mask;

    // Rotate so that bit 0 of the *_rot vectors is the current highest priority level.
    assign w_shift    = w_lowest + 3'd1;
    assign w_pending  = bus.i_interrupt_request_register & ~bus.i_interrupt_mask;
    assign w_pend_dbl = {w_pending, w_pending} >> w_shift;
    assign w_isr_dbl  = {r_isr, r_isr} >> w_shift;
    assign w_pend_rot = w_pend_dbl[7:0];
    assign w_isr_rot  = w_isr_dbl[7:0];

    always_comb begin
        w_pend_idx = '0;
        w_isr_idx  = '0;
        for (int i = 7; i >= 0; i--) begin
            if (w_pend_rot[i]) w_pend_idx = 3'(i);
            if (w_isr_rot[i])  w_isr_idx  = 3'(i);
        end
    end

    assign w_pend_found     = |w_pend_rot;
    assign w_isr_found      = |w_isr_rot;
    assign w_eligible       = w_pend_found && (!w_isr_found || (w_pend_idx < w_isr_idx));
    assign w_eligible_level = w_pend_idx + w_shift;
    assign w_ns_level       = w_isr_idx + w_shift;

    assign w_ns_mask = (bus.i_non_specific_eoi && w_isr_found) ? (8'b1 << w_ns_level) : 8'b0;
    assign w_sp_mask = bus.i_specific_eoi ? (8'b1 << bus.i_eoi_level) : 8'b0;

    // A set from the first INTA wins over any EOI aimed at the same bit.
    assign w_isr_next = (r_isr & ~(w_ns_mask | w_sp_mask | w_aeoi_mask)) | w_set_mask;

    always_comb begin
        w_state_next        = r_state;
        w_set_mask          = '0;
        w_aeoi_mask         = '0;
        w_clear_next        = '0;
        w_level_next        = r_level;
        w_spurious_next     = r_spurious;
        w_freeze_next       = r_freeze;
        w_int_out_next      = 1'b0;
        w_vector_next       = r_vector;
        w_vector_valid_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_int_out_next = r_int_out | w_eligible;
                if (bus.i_interrupt_acknowledge) begin
                    w_state_next   = ST_ACK2;
                    w_freeze_next  = 1'b1;
                    w_int_out_next = 1'b0;
                    if (w_eligible) begin
                        w_level_next    = w_eligible_level;
                        w_spurious_next = 1'b0;
                        w_set_mask      = 8'b1 << w_eligible_level;
                        w_clear_next    = 8'b1 << w_eligible_level;
                    end else begin
                        w_level_next    = SPURIOUS_LEVEL;
                        w_spurious_next = 1'b1;
                    end
                end
            end
            ST_ACK2: begin
                if (bus.i_interrupt_acknowledge) begin
                    w_state_next        = ST_VECTOR;
                    w_vector_next       = {bus.i_vector_base, r_level};
                    w_vector_valid_next = 1'b1;
                    if (bus.i_auto_eoi_config && !r_spurious) w_aeoi_mask = 8'b1 << r_level;
                end
            end
            ST_VECTOR: begin
                w_state_next  = ST_IDLE;
                w_freeze_next = 1'b0;
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_freeze_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_isr          <= '0;
            r_clear        <= '0;
            r_vector       <= '0;
            r_vector_valid <= 1'b0;
            r_freeze       <= 1'b0;
            r_int_out      <= 1'b0;
            r_level        <= '0;
            r_spurious     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_isr          <= w_isr_next;
            r_clear        <= w_clear_next;
            r_vector       <= w_vector_next;
            r_vector_valid <= w_vector_valid_next;
            r_freeze       <= w_freeze_next;
            r_int_out      <= w_int_out_next;
            r_level        <= w_level_next;
            r_spurious     <= w_spurious_next;
        end
    end

`ifdef KF8259_AUTO_ROTATE_EN
    logic [2:0] r_lowest;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_lowest <= 3'd7;
        end else if (bus.i_rotate_on_eoi) begin
            if (|w_ns_mask)
                r_lowest <= w_ns_level;
            else if (bus.i_specific_eoi && r_isr[bus.i_eoi_level])
                r_lowest <= bus.i_eoi_level;
            else if (|w_aeoi_mask)
                r_lowest <= r_level;
        end
    end

    assign w_lowest = r_lowest;
`else
    assign w_lowest = 3'd7;
`endif

    assign bus.o_freeze                  = r_freeze;
    assign bus.o_clear_interrupt_request = r_clear;
    assign bus.o_in_service_register     = r_isr;
    assign bus.o_interrupt_out           = r_interrupt_out_alias();

    function automatic logic r_interrupt_out_alias();
        return r_int_out;
    endfunction

    assign bus.o_vector                  = r_vector;
    assign bus.o_vector_valid            = r_vector_valid;
endmodule

// File: tb/tb_kf8259_interrupt_sequencer.sv
// Randomised scoreboard bench for kf8259_interrupt_sequencer (default fixed-priority build).
module tb_kf8259_interrupt_sequencer;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    kf8259_interrupt_sequencer_if bus();

    kf8259_interrupt_sequencer dut (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    logic [7:0] m_isr;
    logic       m_int;
    logic [7:0] cur_irr, cur_imr;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each presented vector must match the oldest expected one.
    always @(negedge clock) begin
        if (bus.o_vector_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL vector_unexpected: got %02h expected none", bus.o_vector);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.o_vector !== mon_exp) begin
                    n_err++;
                    $display("FAIL vector: got %02h expected %02h at %0t", bus.o_vector, mon_exp, $time);
                end
            end
        end
    end

    // Fixed priority, fully nested: walk IR0..IR7, an in-service level blocks itself and below.
    function automatic int best_lvl(input logic [7:0] irr, input logic [7:0] imr, input logic [7:0] isr);
        int  r;
        bit  blocked;
        r = -1;
        blocked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!blocked && r < 0) begin
                if (isr[i]) blocked = 1'b1;
                else if (irr[i] && !imr[i]) r = i;
            end
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        repeat (2) step();
        if (best_lvl(cur_irr, cur_imr, m_isr) >= 0) m_int = 1'b1;
        check1("interrupt_out", bus.o_interrupt_out, m_int);
        check8("isr_idle", bus.o_in_service_register, m_isr);
    endtask

    task automatic set_req(input logic [7:0] irr, input logic [7:0] imr);
        cur_irr = irr;
        cur_imr = imr;
        bus.i_interrupt_request_register = irr;
        bus.i_interrupt_mask = imr;
        settle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_isr = '0;
        m_int = 1'b0;
        exp_q.delete();
        check8("reset_isr", bus.o_in_service_register, 8'h00);
        check8("reset_clear", bus.o_clear_interrupt_request, 8'h00);
        check8("reset_vector", bus.o_vector, 8'h00);
        check1("reset_freeze", bus.o_freeze, 1'b0);
        check1("reset_int", bus.o_interrupt_out, 1'b0);
        check1("reset_valid", bus.o_vector_valid, 1'b0);
    endtask

    task automatic ns_eoi();
        bus.i_non_specific_eoi = 1'b1;
        step();
        bus.i_non_specific_eoi = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_isr[i]) begin
                m_isr[i] = 1'b0;
                break;
            end
        end
        check8("isr_ns_eoi", bus.o_in_service_register, m_isr);
        settle();
    endtask

    task automatic sp_eoi(input logic [2:0] lv);
        bus.i_specific_eoi = 1'b1;
        bus.i_eoi_level = lv;
        step();
        bus.i_specific_eoi = 1'b0;
        m_isr[lv] = 1'b0;
        check8("isr_sp_eoi", bus.o_in_service_register, m_isr);
        settle();
    endtask

    // Full INTA pair; eoi1 >= 0 adds a specific EOI on the first INTA edge, eoi2 one during ACK2.
    task automatic inta_seq(input bit aeoi, input int eoi1, input bit eoi2, input logic [4:0] base);
        int         l;
        logic [7:0] setm;
        logic [2:0] lv;
        logic [2:0] e;
        l = best_lvl(cur_irr, cur_imr, m_isr);
        setm = (l >= 0) ? (8'h01 << l) : 8'h00;
        lv = (l >= 0) ? 3'(l) : 3'd7;
        bus.i_auto_eoi_config = aeoi;
        bus.i_vector_base = base;
        bus.i_interrupt_acknowledge = 1'b1;
        if (eoi1 >= 0) begin
            bus.i_specific_eoi = 1'b1;
            bus.i_eoi_level = 3'(eoi1);
        end
        step();
        bus.i_interrupt_acknowledge = 1'b0;
        bus.i_specific_eoi = 1'b0;
        if (eoi1 >= 0) m_isr[eoi1] = 1'b0;
        m_isr = m_isr | setm;
        m_int = 1'b0;
        check8("isr_inta1", bus.o_in_service_register, m_isr);
        check8("clear_pulse", bus.o_clear_interrupt_request, setm);
        check1("freeze_inta1", bus.o_freeze, 1'b1);
        check1("int_after_inta1", bus.o_interrupt_out, 1'b0);
        cur_irr = cur_irr & ~setm;
        bus.i_interrupt_request_register = cur_irr;
        step();
        check8("clear_one_cycle", bus.o_clear_interrupt_request, 8'h00);
        check1("freeze_ack2", bus.o_freeze, 1'b1);
        if (eoi2) begin
            e = 3'($urandom_range(0, 7));
            bus.i_specific_eoi = 1'b1;
            bus.i_eoi_level = e;
            step();
            bus.i_specific_eoi = 1'b0;
            m_isr[e] = 1'b0;
            check8("isr_eoi_ack2", bus.o_in_service_register, m_isr);
        end
        bus.i_interrupt_acknowledge = 1'b1;
        step();
        bus.i_interrupt_acknowledge = 1'b0;
        exp_q.push_back({base, lv});
        if (aeoi && l >= 0) m_isr[lv] = 1'b0;
        check8("isr_inta2", bus.o_in_service_register, m_isr);
        check1("valid_inta2", bus.o_vector_valid, 1'b1);
        check1("freeze_vector", bus.o_freeze, 1'b1);
        step();
        check1("valid_drop", bus.o_vector_valid, 1'b0);
        check1("freeze_drop", bus.o_freeze, 1'b0);
        check8("vector_hold", bus.o_vector, {base, lv});
        settle();
    endtask

    initial begin
        reset = 1'b1;
        bus.i_interrupt_request_register = '0;
        bus.i_interrupt_mask = '0;
        bus.i_interrupt_acknowledge = 1'b0;
        bus.i_non_specific_eoi = 1'b0;
        bus.i_specific_eoi = 1'b0;
        bus.i_eoi_level = '0;
        bus.i_auto_eoi_config = 1'b0;
        bus.i_vector_base = '0;
`ifdef KF8259_AUTO_ROTATE_EN
        bus.i_rotate_on_eoi = 1'b0;
`endif
        cur_irr = '0;
        cur_imr = '0;
        m_isr = '0;
        m_int = 1'b0;
        step();
        do_reset();

        // Basic service of IR2 with IR5 also pending.
        set_req(8'h24, 8'h00);
        inta_seq(1'b0, -1, 1'b0, 5'h01);
        ns_eoi();

        // Nested block, then EOI unblocks.
        set_req(8'h02, 8'h00);
        inta_seq(1'b0, -1, 1'b0, 5'h03);
        set_req(8'h28, 8'h00);
        check8("isr_nested", bus.o_in_service_register, 8'h02);
        ns_eoi();

        // Request withdrawn before INTA gives the spurious vector.
        set_req(8'h00, 8'h00);
        inta_seq(1'b0, -1, 1'b0, 5'h1F);

        // AEOI on IR0.
        set_req(8'h01, 8'h00);
        inta_seq(1'b1, -1, 1'b0, 5'h02);

        // Reset while waiting in ACK2.
        set_req(8'h40, 8'h00);
        bus.i_interrupt_acknowledge = 1'b1;
        step();
        bus.i_interrupt_acknowledge = 1'b0;
        cur_irr = cur_irr & ~8'h40;
        bus.i_interrupt_request_register = cur_irr;
        step();
        do_reset();
        settle();

        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: set_req(8'($urandom_range(0, 255) & $urandom_range(0, 255)),
                                 8'($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255)));
                3, 4, 5: inta_seq(1'($urandom_range(0, 1)),
                                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                                  ($urandom_range(0, 3) == 0),
                                  5'($urandom_range(0, 31)));
                6, 7: ns_eoi();
                8: sp_eoi(3'($urandom_range(0, 7)));
                default: if ($urandom_range(0, 4) == 0) begin
                    do_reset();
                    settle();
                end else begin
                    set_req(8'h00, 8'h00);
                end
            endcase
        end

        step();
        check8("vector_queue_drained", 8'(exp_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
